// File: rtl/ssd_scan_if.sv
// ssd_scan_if: digit/control inputs and multiplexed display outputs of ssd_scan_driver
interface ssd_scan_if;
  logic [3:0] digit3;
  logic [3:0] digit2;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       blank_lz;
  logic       blink_en;
  logic [3:0] ssd_ctl;
  logic [7:0] segs;
  modport master (
    output digit3, digit2, digit1, digit0, blank_lz, blink_en,
    input  ssd_ctl, segs
  );
  modport slave (
    input  digit3, digit2, digit1, digit0, blank_lz, blink_en,
    output ssd_ctl, segs
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexes four BCD digits onto a common-anode display with blanking and blink
module ssd_scan_driver #(
  parameter int SCAN_DIV    = 100000,
  parameter int BLINK_TICKS = 500
) (
  input logic        clk,
  input logic        rst_p,
  ssd_scan_if.slave  bus
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]    pos_q, pos_d;
  logic          blink_phase_q, blink_phase_d;
  logic [3:0]    ctl_q, ctl_d;
  logic [7:0]    segs_q, segs_d;
  logic          tick, blink_wrap, lz, dark;
  logic [3:0]    sel;
  function automatic logic [7:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 8'b0000_0011;
      4'd1:    decode = 8'b1001_1111;
      4'd2:    decode = 8'b0010_0101;
      4'd3:    decode = 8'b0000_1101;
      4'd4:    decode = 8'b1001_1001;
      4'd5:    decode = 8'b0100_1001;
      4'd6:    decode = 8'b0100_0001;
      4'd7:    decode = 8'b0001_1111;
      4'd8:    decode = 8'b0000_0001;
      4'd9:    decode = 8'b0000_1001;
      default: decode = 8'b1111_1101;
    endcase
  endfunction
  always_comb begin
    tick          = scan_cnt_q == SCAN_MAX;
    scan_cnt_d    = tick ? '0 : scan_cnt_q + SW'(1);
    pos_d         = tick ? pos_q + 2'd1 : pos_q;
    blink_wrap    = blink_cnt_q == BLINK_MAX;
    // blink state is forced to zero while disabled so each assertion starts visible
    blink_cnt_d   = !bus.blink_en ? '0 : !tick ? blink_cnt_q : blink_wrap ? '0 : blink_cnt_q + BW'(1);
    blink_phase_d = bus.blink_en && (blink_phase_q ^ (tick && blink_wrap));
    sel = pos_q == 2'd0 ? bus.digit0 :
          pos_q == 2'd1 ? bus.digit1 :
          pos_q == 2'd2 ? bus.digit2 : bus.digit3;
    lz  = bus.blank_lz && (
          pos_q == 2'd3 ? bus.digit3 == 4'd0 :
          pos_q == 2'd2 ? bus.digit3 == 4'd0 && bus.digit2 == 4'd0 :
          pos_q == 2'd1 ? bus.digit3 == 4'd0 && bus.digit2 == 4'd0 && bus.digit1 == 4'd0 : 1'b0);
    dark   = bus.blink_en && blink_phase_q;
    ctl_d  = dark ? 4'b1111 : ~(4'b0001 << pos_q);
    segs_d = (dark || lz) ? 8'hFF : decode(sel);
  end
  always_ff @(posedge clk) begin
    if (rst_p) begin
      scan_cnt_q    <= '0;
      pos_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      ctl_q         <= 4'b1111;
      segs_q        <= 8'hFF;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      pos_q         <= pos_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      ctl_q         <= ctl_d;
      segs_q        <= segs_d;
    end
  end
  assign bus.ssd_ctl = ctl_q;
  assign bus.segs    = segs_q;
endmodule
